serial_sub: RTL
===============

Name: serial_sub

Overview:
Bit-serial subtractor stage built around the one-bit full-subtractor cell.
- Computes diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- The borrow is held in a flip-flop between bit cycles.
- Sits directly upstream of result consumers: it presents full parallel diff/bout words with a done pulse.
- Provides the multi-bit, area-cheap wrapper the combinational full-subtractor cell needs.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse; result valid
diff_out  output  WIDTH  difference, held until next done
bout  output  1  final borrow-out, held until next done

Behaviour:
Reset:
- rst high asynchronously forces state=IDLE, busy=0, done=0, diff_out=0, bout=0.
- Shift registers, bit counter and borrow flop are all cleared.
- Applies mid-operation: any in-flight subtraction is discarded with no done pulse.

FSM states: IDLE, SHIFT, DONE.

IDLE:
- busy=0.
- start=1 at a clock edge: load A<=a_in, B<=b_in, borrow<=bin, cnt<=0, R<=0; next state SHIFT.
- start=0: remain in IDLE.

SHIFT (one bit per cycle, using x=A[0], y=B[0]):
- d = x ^ y ^ borrow.
- borrow <= (~x & y) | (~(x ^ y) & borrow).
- R <= {d, R[WIDTH-1:1]}; A and B shift right by one; cnt <= cnt+1.
- When cnt==WIDTH-1, next state DONE after this bit is processed.
- WIDTH=1: exactly one SHIFT cycle.

DONE (one cycle):
- done=1, diff_out<=R, bout<=borrow, all registered so they are visible in the same cycle done is high.
- Next state IDLE unconditionally.

Latency:
- Start accepted at edge 0.
- done high during the cycle following edge WIDTH+1.
- Next start accepted at edge WIDTH+2 at the earliest (throughput one op per WIDTH+2 cycles).

Handshake rules:
- start while busy=1 (SHIFT or DONE) is ignored and not queued.
- a_in/b_in/bin may change freely after acceptance.

Arithmetic:
- diff_out = (a_in - b_in - bin) mod 2^WIDTH.
- bout=1 iff a_in < b_in + bin, treating operands as unsigned.

Outputs:
- diff_out/bout change only in DONE or on reset. Otherwise stable.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), updated together with diff_out in DONE.
- ovf = (borrow into MSB) XOR (borrow out of MSB), i.e. two's-complement signed overflow of a - b - bin.
- The borrow into the MSB is captured in a flop during the last SHIFT cycle.
- ovf resets to 0 and holds between done pulses.
- Undefined: no ovf port, no capture flop; all other behaviour identical.

Test Plan:
1. WIDTH=8, a_in=8'h05, b_in=8'h03, bin=0, start pulse -> done one cycle at edge 9 window, diff_out=8'h02, bout=0, busy high for 9 cycles.
2. a_in=8'h03, b_in=8'h05, bin=0 -> diff_out=8'hFE, bout=1. Then a_in=8'h00, b_in=8'h00, bin=1 -> diff_out=8'hFF, bout=1.
3. a_in=8'hFF, b_in=8'hFF, bin=1 -> diff_out=8'hFF, bout=1. a_in=8'hFF, b_in=8'h00, bin=0 -> diff_out=8'hFF, bout=0.
4. Start with a_in=8'h10, b_in=8'h01; pulse start again at cycle 3 with a_in=8'h00 -> second start ignored, single done, diff_out=8'h0F; back-to-back start at earliest IDLE edge accepted.
5. Start 8'h20-8'h01, assert rst at cycle 4 -> busy=0, diff_out=8'h00, bout=0 immediately (asynchronous); no done pulse; a fresh start afterwards yields correct result.
6. With SERIAL_SUB_OVF_EN defined: 8'h80-8'h01 -> diff_out=8'h7F, ovf=1, bout=0. 8'h7F-8'hFF -> diff_out=8'h80, ovf=1, bout=1. 8'h05-8'h03 -> ovf=0.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b - bin over WIDTH bits.
// One bit is processed per clock, LSB first. The borrow lives in a flop
// between bit cycles. Results are presented as full parallel words with a
// one-cycle done pulse.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_s;
    logic             borrow_r;
    logic             borrow_s;
    logic             d_s;
    logic [5:0]       cnt_r;
    logic             last_s;
    logic             busy_s;
    logic             done_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             msb_bin_r;
`endif

    // Full-subtractor cell: difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor cell: borrow out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: SHIFT runs WIDTH cycles, DONE lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode; values are registered below so the ports are glitch-free.
    always_comb begin
        busy_s = (state_s != IDLE);
        done_s = (state_r == DONE);
    end

    // Bit-slice datapath: apply the full-subtractor cell to the current LSBs.
    always_comb begin
        d_s             = fs_diff(a_r[0], b_r[0], borrow_r);
        borrow_s        = fs_borrow(a_r[0], b_r[0], borrow_r);
        r_s             = r_r >> 1'b1;
        r_s[WIDTH-1]    = d_s;
        last_s          = (cnt_r == 6'(WIDTH - 1));
    end

    // Operand/result shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            r_r      <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r      <= a_in;
                        b_r      <= b_in;
                        borrow_r <= bin;
                        cnt_r    <= 6'd0;
                        r_r      <= '0;
                    end
                end
                SHIFT: begin
                    a_r      <= a_r >> 1'b1;
                    b_r      <= b_r >> 1'b1;
                    borrow_r <= borrow_s;
                    r_r      <= r_s;
                    cnt_r    <= cnt_r + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Capture the borrow entering the MSB during the last bit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_bin_r <= 1'b0;
        end else if ((state_r == SHIFT) && last_s) begin
            msb_bin_r <= borrow_r;
        end
    end
`endif

    // Registered outputs; result words update only when leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            diff_out <= '0;
            bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            busy <= busy_s;
            done <= done_s;
            if (state_r == DONE) begin
                diff_out <= r_r;
                bout     <= borrow_r;
`ifdef SERIAL_SUB_OVF_EN
                ovf      <= msb_bin_r ^ borrow_r;
`endif
            end
        end
    end

endmodule
